// File: rtl/csel_add_seq.sv
// csel_add_seq: sequential carry-select adder, one CHUNK-wide slice per cycle.
// Ports:
//   clk, rst (async active-high)
//   in_valid/in_ready, a, b, cin, sub : operand handshake
//   out_valid/out_ready, sum, cout    : result handshake
//   busy                              : operation in progress
// Optional macro CSEL_SUB_EN enables a - b when sub is set at accept.
module csel_add_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [IW-1:0]    r_idx;
    logic             r_carry;
    logic             r_cout;

    logic [31:0]      w_base;
    logic [CHUNK-1:0] w_a_sl;
    logic [CHUNK-1:0] w_b_sl;
    logic [CHUNK:0]   w_s0;
    logic [CHUNK:0]   w_s1;
    logic [CHUNK:0]   w_sel;
    logic             w_last;
    logic             w_accept;

    assign w_base = 32'(r_idx) * 32'(CHUNK);
    assign w_a_sl = r_a[w_base +: CHUNK];
    assign w_b_sl = r_b[w_base +: CHUNK];

    // Both carry hypotheses are formed; the stored carry picks one.
    assign w_s0  = {1'b0, w_a_sl} + {1'b0, w_b_sl};
    assign w_s1  = {1'b0, w_a_sl} + {1'b0, w_b_sl}
                 + {{CHUNK{1'b0}}, 1'b1};
    assign w_sel = r_carry ? w_s1 : w_s0;

    assign w_last   = (r_idx == IW'(NCHUNK - 1));
    assign w_accept = in_valid && in_ready;

    // in_ready is masked while rst is held so nothing is taken in reset.
    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign sum       = r_sum;
    assign cout      = r_cout;

`ifndef CSEL_SUB_EN
    logic w_unused_sub;
    assign w_unused_sub = sub;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a   <= a;
                        r_sum <= '0;
                        r_idx <= '0;
`ifdef CSEL_SUB_EN
                        // Subtract as a + ~b + 1; cin is ignored.
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub | cin;
`else
                        r_b     <= b;
                        r_carry <= cin;
`endif
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum[w_base +: CHUNK] <= w_sel[CHUNK-1:0];
                    r_carry                <= w_sel[CHUNK];
                    if (w_last) begin
                        r_cout  <= w_sel[CHUNK];
                        r_idx   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csel_add_seq.sv
// tb_csel_add_seq: directed + randomized checks of csel_add_seq
// against an arithmetic reference model.
module tb_csel_add_seq;

    localparam int W = 32;
    localparam int C = 8;
    localparam int N = W / C;
`ifdef CSEL_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int errors = 0;
    int checks = 0;

    csel_add_seq #(.WIDTH(W), .CHUNK(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer add, or a - b with no-borrow flag.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                         input logic mcin, input logic msub,
                         output logic [W-1:0] es, output logic ec);
        logic [W:0] t;
        if (SUB_EN && msub) begin
            es = ma - mb;
            ec = (ma >= mb);
        end else begin
            t  = {1'b0, ma} + {1'b0, mb} + (W+1)'(mcin);
            es = t[W-1:0];
            ec = t[W];
        end
    endtask

    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic tcin, input logic tsub, input int hold);
        logic [W-1:0] es;
        logic         ec;
        model(ta, tb, tcin, tsub, es, ec);
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        a = ta; b = tb; cin = tcin; sub = tsub;
        in_valid = 1; out_ready = 0;
        @(posedge clk); #1;
        for (int k = 1; k <= N; k++) begin
            // Garbage requests while running must be ignored.
            if (k < N) begin
                in_valid = 1;
                a = $urandom; b = $urandom;
                cin = 1'($urandom); sub = 1'($urandom);
            end else begin
                in_valid = 0;
            end
            @(posedge clk); #1;
            chk("latency_out_valid", out_valid, (k == N));
            chk("busy_run", busy, 1);
        end
        chk("sum", sum, es);
        chk("cout", cout, ec);
        chk("done_in_ready", in_ready, 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_out_valid", out_valid, 1);
            chk("hold_sum", sum, es);
            chk("hold_cout", cout, ec);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1;
        @(posedge clk); #1;
        chk("release_out_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
        out_ready = 0;
    endtask

    initial begin
        int acc[$];
        logic [W-1:0] es;
        logic         ec;
        bit           drained;

        rst = 1; in_valid = 0; out_ready = 0;
        a = '0; b = '0; cin = 0; sub = 0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        @(negedge clk);
        rst = 0;
        #1;
        chk("rst_in_ready", in_ready, 1);

        op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 0);
        op(32'h12345678, 32'h11111111, 1'b1, 1'b0, 3);
        op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1);
        op(32'h00000000, 32'h00000000, 1'b0, 1'b0, 0);
        op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 0);
        op(32'h00000005, 32'h00000007, 1'b0, 1'b1, 0);
        op(32'h00000007, 32'h00000005, 1'b1, 1'b1, 0);

        for (int i = 0; i < 24; i++) begin
            op($urandom, $urandom, 1'($urandom), 1'($urandom),
               int'($urandom_range(0, 2)));
        end

        // Reset in the middle of RUN aborts the operation.
        @(negedge clk);
        a = 32'hDEADBEEF; b = 32'h01234567; cin = 1; sub = 0;
        in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        @(negedge clk);
        rst = 0;
        #1;
        chk("abort_in_ready", in_ready, 1);
        @(posedge clk); #1;
        chk("abort_no_result", out_valid, 0);
        op(32'd1, 32'd2, 1'b0, 1'b0, 0);

        // Back-to-back with in_valid and out_ready held high.
        @(negedge clk);
        a = 32'hA5A5A5A5; b = 32'h5A5A5A5B; cin = 0; sub = 0;
        model(a, b, cin, sub, es, ec);
        in_valid = 1; out_ready = 1;
        for (int cy = 0; cy < 3 * (N + 2); cy++) begin
            if (in_ready) acc.push_back(cy);
            if (out_valid) begin
                chk("b2b_sum", sum, es);
                chk("b2b_cout", cout, ec);
            end
            @(negedge clk);
        end
        chk("b2b_accepts", acc.size(), 3);
        if (acc.size() == 3) begin
            chk("b2b_gap1", acc[1] - acc[0], N + 2);
            chk("b2b_gap2", acc[2] - acc[1], N + 2);
        end
        in_valid = 0;
        drained = 0;
        for (int cy = 0; cy < 2 * N + 4 && !drained; cy++) begin
            if (in_ready) drained = 1;
            else @(negedge clk);
        end
        chk("b2b_drain", drained, 1);
        out_ready = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
